// File: rtl/itrx_aib_phy_clk_sel_seq_pkg.sv
// Shared types and elaboration helpers for the AIB PHY clock-select sequencer.
package itrx_aib_phy_clk_sel_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GATE_OFF = 3'd1,
        ST_SWITCH   = 3'd2,
        ST_GATE_ON  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Ceiling log2, constant-evaluable for parameter widths.
    function automatic int unsigned clog2_f(input int unsigned val);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(val)) res = i + 1;
        end
        return res;
    endfunction

    function automatic int unsigned max_f(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/itrx_aib_phy_clk_sel_seq_cnt.sv
// Loadable down-counter with zero flag; reloaded on every timed-state entry.
module itrx_aib_phy_clk_sel_seq_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/itrx_aib_phy_clk_sel_seq.sv
// N-way clock-select sequencer: gate off, settle, switch mux, settle, gate on.
// The mux select only moves while every source gate is closed.
module itrx_aib_phy_clk_sel_seq
    import itrx_aib_phy_clk_sel_seq_pkg::*;
#(
    parameter int unsigned NUM_CLK  = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned GATE_DLY = 2,
    parameter int unsigned SW_DLY   = 2,
    parameter int unsigned RST_SEL  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEL_W-1:0]   sel_req,
    input  logic               sel_req_vld,
    output logic               sel_req_rdy,
    input  logic               out_en,
    output logic [NUM_CLK-1:0] clk_en,
    output logic [SEL_W-1:0]   mux_sel,
    output logic [SEL_W-1:0]   sel_cur,
    output logic               busy,
    output logic               sw_done,
    output logic               sel_err
);

    localparam int unsigned          CNT_W     = clog2_f(max_f(GATE_DLY, SW_DLY) + 1);
    localparam logic [CNT_W-1:0]     GATE_LD   = CNT_W'(GATE_DLY - 1);
    localparam logic [CNT_W-1:0]     SW_LD     = CNT_W'(SW_DLY - 1);
    localparam logic [SEL_W-1:0]     RST_SEL_V = SEL_W'(RST_SEL);
    localparam logic [NUM_CLK-1:0]   RST_EN    = NUM_CLK'(1) << RST_SEL;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   tgt_q, tgt_d;
    logic [NUM_CLK-1:0] en_q, en_d;
    logic [SEL_W-1:0]   mux_q, mux_d;
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic               busy_q, done_q, done_d, err_q, err_d;

    logic               accept, req_bad, req_same;
    logic               cnt_load, cnt_zero;
    logic [CNT_W-1:0]   cnt_ld_val;

    assign accept   = sel_req_vld && (state_q == ST_IDLE);
    assign req_bad  = 32'(sel_req) >= NUM_CLK;
    assign req_same = (sel_req == cur_q);

    assign cnt_load   = (state_d != state_q);
    assign cnt_ld_val = (state_d == ST_SWITCH) ? SW_LD : GATE_LD;

    itrx_aib_phy_clk_sel_seq_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .zero_c   (cnt_zero)
    );

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tgt_q   <= RST_SEL_V;
            en_q    <= RST_EN;
            mux_q   <= RST_SEL_V;
            cur_q   <= RST_SEL_V;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            en_q    <= en_d;
            mux_q   <= mux_d;
            cur_q   <= cur_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept && !req_bad) state_d = req_same ? ST_DONE : ST_GATE_OFF;
            ST_GATE_OFF: if (cnt_zero) state_d = ST_SWITCH;
            ST_SWITCH:   if (cnt_zero) state_d = ST_GATE_ON;
            ST_GATE_ON:  if (cnt_zero) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, keyed on the transition taken
    always_comb begin
        tgt_d  = tgt_q;
        en_d   = en_q;
        mux_d  = mux_q;
        cur_d  = cur_q;
        err_d  = 1'b0;
        done_d = (state_d == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else if (!req_same) begin
                        tgt_d = sel_req;
                        en_d  = '0;
                    end
                end
            end
            ST_GATE_OFF: if (cnt_zero) mux_d = tgt_q;
            ST_SWITCH: begin
                if (cnt_zero) begin
                    en_d  = NUM_CLK'(1) << tgt_q;
                    cur_d = tgt_q;
                end
            end
            default: ;
        endcase
    end

    assign sel_req_rdy = (state_q == ST_IDLE);
    assign clk_en      = en_q & {NUM_CLK{out_en}};
    assign mux_sel     = mux_q;
    assign sel_cur     = cur_q;
    assign busy        = busy_q;
    assign sw_done     = done_q;
    assign sel_err     = err_q;

endmodule

// File: tb/tb_itrx_aib_phy_clk_sel_seq.sv
// Self-checking bench for itrx_aib_phy_clk_sel_seq: directed and randomized requests
// checked cycle by cycle against a timeline model of the switch sequence.
module tb_itrx_aib_phy_clk_sel_seq;

    localparam int G = 2;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] sel_req;
    logic       sel_req_vld;
    logic       sel_req_rdy;
    logic       out_en;
    logic [3:0] clk_en;
    logic [1:0] mux_sel;
    logic [1:0] sel_cur;
    logic       busy, sw_done, sel_err;

    logic [2:0] sel_req_b;
    logic       sel_req_vld_b, sel_req_rdy_b, out_en_b;
    logic [4:0] clk_en_b;
    logic [2:0] mux_sel_b, sel_cur_b;
    logic       busy_b, sw_done_b, sel_err_b;

    int checks = 0;
    int errors = 0;

    logic [1:0] m_cur;
    logic       m_oe;
    logic [1:0] prev_mux;
    logic [3:0] prev_en;

    always #5 clk = ~clk;

    itrx_aib_phy_clk_sel_seq #(
        .NUM_CLK(4), .SEL_W(2), .GATE_DLY(G), .SW_DLY(S), .RST_SEL(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .sel_req_vld(sel_req_vld),
        .sel_req_rdy(sel_req_rdy), .out_en(out_en), .clk_en(clk_en), .mux_sel(mux_sel),
        .sel_cur(sel_cur), .busy(busy), .sw_done(sw_done), .sel_err(sel_err)
    );

    itrx_aib_phy_clk_sel_seq #(
        .NUM_CLK(5), .SEL_W(3), .GATE_DLY(G), .SW_DLY(S), .RST_SEL(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .sel_req(sel_req_b), .sel_req_vld(sel_req_vld_b),
        .sel_req_rdy(sel_req_rdy_b), .out_en(out_en_b), .clk_en(clk_en_b), .mux_sel(mux_sel_b),
        .sel_cur(sel_cur_b), .busy(busy_b), .sw_done(sw_done_b), .sel_err(sel_err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [3:0] en, input logic [1:0] mx,
                                         input logic [1:0] cr, input logic rdy,
                                         input logic bsy, input logic dn, input logic er);
        return {20'd0, en, mx, cr, rdy, bsy, dn, er};
    endfunction

    function automatic logic [31:0] pack_b(input logic [4:0] en, input logic [2:0] mx,
                                           input logic [2:0] cr, input logic rdy,
                                           input logic bsy, input logic dn, input logic er);
        return {17'd0, en, mx, cr, rdy, bsy, dn, er};
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] s);
        logic [3:0] v;
        v = 4'd0;
        v[s] = 1'b1;
        return v;
    endfunction

    // out_en pattern: 0 = always high, 1 = random, 2 = low across the gate-on window
    function automatic logic oe_val(input int mode, input int k);
        if (mode == 1) return 1'($urandom_range(1, 0));
        if (mode == 2) return !(k > G + S && k <= 2 * G + S);
        return 1'b1;
    endfunction

    // Compare all outputs for this cycle, and flag any select move while a gate is open
    task automatic cyc_check(input string tag, input logic [31:0] exp);
        chk(tag, pack(clk_en, mux_sel, sel_cur, sel_req_rdy, busy, sw_done, sel_err), exp);
        if (mux_sel !== prev_mux)
            chk("mux_while_gated", {28'd0, prev_en | clk_en}, 32'd0);
        prev_mux = mux_sel;
        prev_en  = clk_en;
    endtask

    task automatic idle(input int n);
        sel_req_vld = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            cyc_check("idle", pack(onehot(m_cur) & {4{m_oe}}, m_cur, m_cur, 1'b1, 1'b0, 1'b0, 1'b0));
        end
    endtask

    // Issue one request and check every cycle up to and including the first idle cycle after it
    task automatic run_req(input logic [1:0] t, input bit noise, input int mode);
        bit         same;
        int         last;
        logic [3:0] en;
        logic [1:0] mx, cr;
        logic       dn, bsy;
        same        = (t == m_cur);
        last        = same ? 1 : 2 * G + S + 1;
        sel_req     = t;
        sel_req_vld = 1'b1;
        m_oe        = oe_val(mode, 1);
        out_en      = m_oe;
        for (int k = 1; k <= last + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            en = onehot(m_cur);
            mx = m_cur;
            cr = m_cur;
            dn = 1'b0;
            if (same) begin
                dn = (k == 1);
            end else if (k <= G) begin
                en = 4'd0;
            end else if (k <= G + S) begin
                en = 4'd0;
                mx = t;
            end else begin
                en = onehot(t);
                mx = t;
                cr = t;
                dn = (k == last);
            end
            bsy = (k <= last);
            cyc_check($sformatf("req%0d_k%0d", t, k), pack(en & {4{m_oe}}, mx, cr, !bsy, bsy, dn, 1'b0));
            if (k <= last) begin
                sel_req_vld = noise;
                sel_req     = 2'($urandom);
            end
            m_oe   = oe_val(mode, k + 1);
            out_en = m_oe;
        end
        m_cur = t;
    endtask

    initial begin
        rst_n         = 1'b0;
        sel_req       = 2'd0;
        sel_req_vld   = 1'b0;
        out_en        = 1'b1;
        sel_req_b     = 3'd0;
        sel_req_vld_b = 1'b0;
        out_en_b      = 1'b1;
        m_cur         = 2'd0;
        m_oe          = 1'b1;
        prev_mux      = 2'd0;
        prev_en       = 4'b0001;

        repeat (3) @(negedge clk);
        cyc_check("reset", pack(4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        chk("reset_b", pack_b(clk_en_b, mux_sel_b, sel_cur_b, sel_req_rdy_b, busy_b, sw_done_b, sel_err_b),
            pack_b(5'b00001, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        rst_n = 1'b1;
        idle(2);

        // Directed: 0->2, same-source, out_en drop in gate-on, held-valid back-to-back
        run_req(2'd2, 1'b0, 0);
        run_req(2'd1, 1'b0, 0);
        run_req(2'd1, 1'b0, 0);
        run_req(2'd0, 1'b0, 0);
        run_req(2'd3, 1'b0, 2);
        run_req(2'd1, 1'b1, 0);
        run_req(2'd2, 1'b1, 0);
        run_req(2'd0, 1'b0, 0);
        idle(1);

        // Out-of-range and top-boundary requests on the five-source instance
        sel_req_b = 3'd5;
        sel_req_vld_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sel_req_vld_b = 1'b0;
        chk("err_5", pack_b(clk_en_b, mux_sel_b, sel_cur_b, sel_req_rdy_b, busy_b, sw_done_b, sel_err_b),
            pack_b(5'b00001, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        sel_req_b = 3'd7;
        sel_req_vld_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sel_req_vld_b = 1'b0;
        chk("err_7", pack_b(clk_en_b, mux_sel_b, sel_cur_b, sel_req_rdy_b, busy_b, sw_done_b, sel_err_b),
            pack_b(5'b00001, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1));
        @(posedge clk);
        @(negedge clk);
        chk("err_clear", pack_b(clk_en_b, mux_sel_b, sel_cur_b, sel_req_rdy_b, busy_b, sw_done_b, sel_err_b),
            pack_b(5'b00001, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        sel_req_b = 3'd4;
        sel_req_vld_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sel_req_vld_b = 1'b0;
        chk("b4_k1", pack_b(clk_en_b, mux_sel_b, sel_cur_b, sel_req_rdy_b, busy_b, sw_done_b, sel_err_b),
            pack_b(5'b00000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        repeat (6) @(negedge clk);
        chk("b4_k7", pack_b(clk_en_b, mux_sel_b, sel_cur_b, sel_req_rdy_b, busy_b, sw_done_b, sel_err_b),
            pack_b(5'b10000, 3'd4, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0));

        // Reset asserted mid-switch 0->2 at cycle 4
        sel_req     = 2'd2;
        sel_req_vld = 1'b1;
        out_en      = 1'b1;
        m_oe        = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            sel_req_vld = 1'b0;
        end
        chk("mid_k4", pack(clk_en, mux_sel, sel_cur, sel_req_rdy, busy, sw_done, sel_err),
            pack(4'b0000, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        rst_n = 1'b0;
        #1;
        chk("mid_rst", pack(clk_en, mux_sel, sel_cur, sel_req_rdy, busy, sw_done, sel_err),
            pack(4'b0001, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0));
        prev_mux = 2'd0;
        prev_en  = 4'b0001;
        m_cur    = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_req(2'd0, 1'b0, 0);

        // Randomized requests with noisy held-valid and random out_en
        for (int i = 0; i < 40; i++) begin
            run_req(2'($urandom), 1'($urandom_range(1, 0)), int'($urandom_range(1, 0)));
            if ($urandom_range(2, 0) == 0) idle(int'($urandom_range(2, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
